inst_arbiter: RTL and testbench

- Shares one peripheral instruction bus (oreg/oreg_wen, the bus that feeds Alu, Swc, LedBank and VGA) between NUM_REQ instruction sources, e.g. two Seq instances.
- Each requester posts an instruction word plus a one-hot target enable into a one-entry holding slot.
- A round-robin scheduler issues at most one instruction per cycle onto a registered output bus.
- Sits between the sequencers' oreg/oreg_wen outputs and the peripheral inst/inst_en inputs.

---
 rtl/inst_arbiter_pkg.sv | 16 +
 rtl/inst_arbiter_if.sv | 31 +++
 rtl/inst_arbiter_rr_pick.sv | 53 +++++
 rtl/inst_arbiter.sv | 91 +++++++++
 tb/tb_inst_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/inst_arbiter_pkg.sv
// Shared definitions for the instruction-bus arbiter and the sequencer-side code:
// default word widths and the index-width helper.
package inst_arbiter_pkg;

    localparam int unsigned INST_WIDTH_DEF = 12;
    localparam int unsigned WEN_WIDTH_DEF  = 8;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/inst_arbiter_if.sv
// Requester-side handshake and issued-instruction bus of inst_arbiter.
// The sequencers drive through master; the arbiter uses slave.
interface inst_arbiter_if
    import inst_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned INST_WIDTH = INST_WIDTH_DEF,
    parameter int unsigned WEN_WIDTH  = WEN_WIDTH_DEF
);
    localparam int unsigned GW = clog2_min1(NUM_REQ);

    logic [NUM_REQ*INST_WIDTH-1:0] req_inst;
    logic [NUM_REQ*WEN_WIDTH-1:0]  req_wen;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [INST_WIDTH-1:0]         oreg;
    logic [WEN_WIDTH-1:0]          oreg_wen;
    logic [GW-1:0]                 grant_id;
    logic                          busy;

    modport master (
        output req_inst, req_wen, req_valid,
        input  req_ready, oreg, oreg_wen, grant_id, busy
    );

    modport slave (
        input  req_inst, req_wen, req_valid,
        output req_ready, oreg, oreg_wen, grant_id, busy
    );

endinterface

// File: rtl/inst_arbiter_rr_pick.sv
// Combinational winner picker: first full slot after the pointer, wrapping.
// Define INST_ARB_FIXED_PRIO_EN for lowest-index-wins with a frozen pointer.
module inst_arbiter_rr_pick
    import inst_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]               full_i,
    input  logic [clog2_min1(NUM_REQ)-1:0]   ptr_i,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [clog2_min1(NUM_REQ)-1:0]   idx_o,
    output logic                             any_o,
    output logic [clog2_min1(NUM_REQ)-1:0]   ptr_o
);
    localparam int unsigned GW = clog2_min1(NUM_REQ);

`ifdef INST_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        ptr_o = ptr_i;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_o && full_i[i]) begin
                any_o    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = GW'(i);
            end
        end
    end
`else
    logic [GW-1:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        ptr_o = ptr_i;
        pos   = '0;
        // Scan ptr+1 .. ptr+NUM_REQ so the last winner is considered last.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            pos = GW'((32'(ptr_i) + k) % NUM_REQ);
            if (!any_o && full_i[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
        if (any_o) ptr_o = idx_o;
    end
`endif

endmodule

// File: rtl/inst_arbiter.sv
// Shares the peripheral instruction bus between NUM_REQ sequencers through
// one-entry holding slots and a registered issue stage.
module inst_arbiter
    import inst_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned INST_WIDTH = INST_WIDTH_DEF,
    parameter int unsigned WEN_WIDTH  = WEN_WIDTH_DEF
) (
    input  logic         clock,
    input  logic         reset,
    inst_arbiter_if.slave bus
);
    localparam int unsigned GW = clog2_min1(NUM_REQ);

    logic [NUM_REQ-1:0]    full_q, full_d;
    logic [INST_WIDTH-1:0] inst_q [NUM_REQ];
    logic [INST_WIDTH-1:0] inst_d [NUM_REQ];
    logic [WEN_WIDTH-1:0]  wen_q  [NUM_REQ];
    logic [WEN_WIDTH-1:0]  wen_d  [NUM_REQ];
    logic [INST_WIDTH-1:0] oreg_q, oreg_d;
    logic [WEN_WIDTH-1:0]  oreg_wen_q, oreg_wen_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         ptr_q, ptr_d;

    logic [NUM_REQ-1:0]    gnt;
    logic [GW-1:0]         idx;
    logic                  any;

    inst_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .full_i (full_q),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .idx_o  (idx),
        .any_o  (any),
        .ptr_o  (ptr_d)
    );

    always_comb begin
        full_d     = full_q;
        inst_d     = inst_q;
        wen_d      = wen_q;
        oreg_d     = oreg_q;
        oreg_wen_d = '0;
        grant_d    = grant_q;
        // Capture only into empty slots and drain only full ones, so the two
        // never meet on the same slot; a zero-enable word is taken and dropped.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) full_d[i] = 1'b0;
            if (bus.req_valid[i] && !full_q[i]) begin
                inst_d[i] = bus.req_inst[i*INST_WIDTH +: INST_WIDTH];
                wen_d[i]  = bus.req_wen[i*WEN_WIDTH +: WEN_WIDTH];
                full_d[i] = |bus.req_wen[i*WEN_WIDTH +: WEN_WIDTH];
            end
        end
        if (any) begin
            oreg_d     = inst_q[idx];
            oreg_wen_d = wen_q[idx];
            grant_d    = idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            full_q     <= '0;
            oreg_q     <= '0;
            oreg_wen_q <= '0;
            grant_q    <= '0;
            ptr_q      <= GW'(NUM_REQ - 1);
        end else begin
            full_q     <= full_d;
            oreg_q     <= oreg_d;
            oreg_wen_q <= oreg_wen_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
        end
    end

    // Slot payload is qualified by full_q, so it needs no reset.
    always_ff @(posedge clock) begin
        inst_q <= inst_d;
        wen_q  <= wen_d;
    end

    assign bus.req_ready = ~full_q;
    assign bus.oreg      = oreg_q;
    assign bus.oreg_wen  = oreg_wen_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (|full_q) | (|oreg_wen_q);

endmodule

// File: tb/tb_inst_arbiter.sv
// Directed self-checking bench for inst_arbiter (NUM_REQ=2, 12-bit words, 8-bit enables).
module tb_inst_arbiter;
    import inst_arbiter_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned IW = 12;
    localparam int unsigned WW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int unsigned tests_run    = 0;
    int unsigned tests_failed = 0;

    inst_arbiter_if #(.NUM_REQ(NR), .INST_WIDTH(IW), .WEN_WIDTH(WW)) bus_if ();

    inst_arbiter #(.NUM_REQ(NR), .INST_WIDTH(IW), .WEN_WIDTH(WW)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic post(input int unsigned i, input logic [IW-1:0] inst, input logic [WW-1:0] wen);
        bus_if.req_inst[i*IW +: IW] = inst;
        bus_if.req_wen[i*WW +: WW]  = wen;
        bus_if.req_valid[i]         = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus_if.req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_issue(input string tag, input logic [IW-1:0] inst,
                               input logic [WW-1:0] wen, input logic gid);
        check({tag, ".oreg"},     32'(bus_if.oreg),     32'(inst));
        check({tag, ".oreg_wen"}, 32'(bus_if.oreg_wen), 32'(wen));
        check({tag, ".grant_id"}, 32'(bus_if.grant_id), 32'(gid));
    endtask

    logic exp_g;

    initial begin
        bus_if.req_inst  = '0;
        bus_if.req_wen   = '0;
        bus_if.req_valid = '0;

        // Reset values
        do_reset();
        check("rst.ready",    32'(bus_if.req_ready), 32'h3);
        check("rst.oreg",     32'(bus_if.oreg),      32'h0);
        check("rst.oreg_wen", 32'(bus_if.oreg_wen),  32'h0);
        check("rst.grant",    32'(bus_if.grant_id),  32'h0);
        check("rst.busy",     32'(bus_if.busy),      32'h0);

        // Single uncontended transfer: capture, issue, idle
        post(0, 12'h1A5, 8'h01);
        tick();
        bus_if.req_valid = '0;
        check("s1.cap.ready", 32'(bus_if.req_ready), 32'h2);
        check("s1.cap.wen",   32'(bus_if.oreg_wen),  32'h0);
        check("s1.cap.busy",  32'(bus_if.busy),      32'h1);
        tick();
        check_issue("s1.iss", 12'h1A5, 8'h01, 1'b0);
        check("s1.iss.ready", 32'(bus_if.req_ready), 32'h3);
        check("s1.iss.busy",  32'(bus_if.busy),      32'h1);
        tick();
        check("s1.idle.wen",  32'(bus_if.oreg_wen),  32'h0);
        check("s1.idle.oreg", 32'(bus_if.oreg),      32'h1A5);
        check("s1.idle.busy", 32'(bus_if.busy),      32'h0);

        // Pointer now at 0: simultaneous post; round-robin favours req1,
        // fixed priority favours req0
`ifdef INST_ARB_FIXED_PRIO_EN
        exp_g = 1'b0;
`else
        exp_g = 1'b1;
`endif
        post(0, 12'h101, 8'h01);
        post(1, 12'h202, 8'h04);
        tick();
        bus_if.req_valid = '0;
        check("s2a.cap.ready", 32'(bus_if.req_ready), 32'h0);
        tick();
        check_issue("s2a.first", exp_g ? 12'h202 : 12'h101, exp_g ? 8'h04 : 8'h01, exp_g);
        check("s2a.first.ready", 32'(bus_if.req_ready), exp_g ? 32'h2 : 32'h1);
        tick();
        check_issue("s2a.second", exp_g ? 12'h101 : 12'h202, exp_g ? 8'h01 : 8'h04, ~exp_g);
        check("s2a.second.ready", 32'(bus_if.req_ready), 32'h3);
        tick();
        check("s2a.idle.wen",  32'(bus_if.oreg_wen), 32'h0);
        check("s2a.idle.busy", 32'(bus_if.busy),     32'h0);

        // Fresh reset: simultaneous post issues req0 then req1
        do_reset();
        post(0, 12'h101, 8'h01);
        post(1, 12'h202, 8'h04);
        tick();
        bus_if.req_valid = '0;
        tick();
        check_issue("s2b.first", 12'h101, 8'h01, 1'b0);
        tick();
        check_issue("s2b.second", 12'h202, 8'h04, 1'b1);
        tick();
        check("s2b.idle.wen", 32'(bus_if.oreg_wen), 32'h0);

        // Continuous posting from both: alternate every cycle, multi-hot wen forwarded
        do_reset();
        post(0, 12'h3A0, 8'h02);
        post(1, 12'h3B1, 8'h0C);
        tick();
        check("s3.cap.ready", 32'(bus_if.req_ready), 32'h0);
        for (int unsigned k = 1; k <= 8; k++) begin
            tick();
            if (k % 2 == 1) check_issue($sformatf("s3.c%0d", k), 12'h3A0, 8'h02, 1'b0);
            else            check_issue($sformatf("s3.c%0d", k), 12'h3B1, 8'h0C, 1'b1);
        end
        bus_if.req_valid = '0;
        tick();
        check_issue("s3.drain", 12'h3A0, 8'h02, 1'b0);
        tick();
        tick();
        check("s3.end.wen",  32'(bus_if.oreg_wen), 32'h0);
        check("s3.end.busy", 32'(bus_if.busy),     32'h0);

        // Zero enable: accepted, dropped, never issued
        do_reset();
        post(1, 12'h2FF, 8'h00);
        tick();
        bus_if.req_valid = '0;
        check("s4.cap.ready", 32'(bus_if.req_ready), 32'h3);
        check("s4.cap.busy",  32'(bus_if.busy),      32'h0);
        tick();
        check("s4.n1.wen",  32'(bus_if.oreg_wen), 32'h0);
        check("s4.n1.busy", 32'(bus_if.busy),     32'h0);
        tick();
        check("s4.n2.wen",  32'(bus_if.oreg_wen), 32'h0);
        check("s4.n2.oreg", 32'(bus_if.oreg),     32'h0);

        // Reset while both slots are full discards them
        post(0, 12'h5A5, 8'h10);
        post(1, 12'h6B6, 8'h20);
        tick();
        bus_if.req_valid = '0;
        check("s5.full.ready", 32'(bus_if.req_ready), 32'h0);
        reset = 1'b1;
        tick();
        check("s5.rst.ready", 32'(bus_if.req_ready), 32'h3);
        check("s5.rst.wen",   32'(bus_if.oreg_wen),  32'h0);
        check("s5.rst.busy",  32'(bus_if.busy),      32'h0);
        reset = 1'b0;
        tick();
        check("s5.post.wen",   32'(bus_if.oreg_wen),  32'h0);
        check("s5.post.ready", 32'(bus_if.req_ready), 32'h3);
        check("s5.post.grant", 32'(bus_if.grant_id),  32'h0);
        check("s5.post.busy",  32'(bus_if.busy),      32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
